tile_renderer: RTL and testbench
================================

TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 Parameter WALL_FG, default 24'hC0C0C0, RGB of lit wall-tile pixels.
REQ-002 Parameter WALL_BG, default 24'h404040, RGB of unlit wall-tile pixels.
REQ-003 Parameter FLOOR_FG, default 24'h208020, RGB of lit floor-tile pixels.
REQ-004 Parameter FLOOR_BG, default 24'h102010, RGB of unlit floor-tile pixels.
REQ-005 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 DrawX  input  10  screen pixel column from the VGA controller.
REQ-008 DrawY  input  10  screen pixel row from the VGA controller.
REQ-009 pix_valid  input  1  DrawX/DrawY are meaningful this cycle.
REQ-010 map_we  input  1  tile-map write strobe.
REQ-011 map_waddr  input  9  tile-map index, 20*tileY + tileX, legal range 0..299.
REQ-012 map_wdata  input  1  tile id to store; 0 = wall, 1 = floor.
REQ-013 rom_addr  output  6  sprite ROM row address {tile id, local row[4:0]}.
REQ-014 rom_data  input  32  sprite ROM row, combinational response to rom_addr; bit 31 = leftmost pixel.
REQ-015 out_valid  output  1  pix_valid delayed to align with the colour outputs.
REQ-016 is_lit  output  1  selected sprite bit of the current pixel.
REQ-017 Red, Green, Blue  output  8 each  pixel colour.

Function
REQ-018 Tile map SHALL be a 300-entry x 1-bit register array: 20 columns x 15 rows of 32x32-pixel tiles covering 640x480.
REQ-019 map_we high with map_waddr <= 299 SHALL write map_wdata at the next edge; map_waddr >= 300 SHALL be ignored, with no aliasing.
REQ-020 Stage A (edge t) SHALL register DrawX, DrawY and pix_valid, plus in_range = (DrawX < 640) && (DrawY < 480).
REQ-021 Stage A SHALL also register tile_A = map[20*DrawY[8:5] + DrawX[9:5]] when in_range, and 0 otherwise.
REQ-022 A map write and stage-A read of the same index on the same edge SHALL return the old value (read-before-write).
REQ-023 rom_addr SHALL be driven combinationally from stage A as {tile_A, DrawY_A[4:0]}.
REQ-024 Stage B (edge t+1) SHALL register bit = rom_data[31 - DrawX_A[4:0]], plus tile_A, in_range_A and valid_A.
REQ-025 Outputs SHALL come directly from stage B registers: latency = 2 edges, throughput = 1 pixel/clock, no stalls.
REQ-026 is_lit SHALL equal bit && in_range_B.
REQ-027 Colour SHALL be {Red,Green,Blue} = FG/BG of the stage-B tile id, selected by is_lit.
REQ-028 Out-of-range pixels SHALL output 24'h000000 with is_lit = 0.
REQ-029 out_valid SHALL equal valid_B; colour and is_lit SHALL be computed regardless of pix_valid.

Reset
REQ-030 Reset high at an edge SHALL clear all stage A/B registers, so rom_addr = 0, out_valid = 0, is_lit = 0 and RGB = 0 after that edge.
REQ-031 Reset SHALL clear every tile-map entry to 0 (wall) and SHALL take priority over a simultaneous map write.
REQ-032 Reset asserted mid-stream SHALL flush both stages; the first output after deassertion reflects inputs sampled at the first edge with Reset low.

Verification
REQ-033 After reset, drive DrawX = 0, DrawY = 0, pix_valid = 1 -> rom_addr = 0 after edge 1; out_valid = 1, is_lit = 1, RGB = WALL_FG after edge 2.
REQ-034 Write map[21] = 1, then drive DrawX = 37, DrawY = 33 -> rom_addr = 33, selected bit 26 of row 0x07F81FE0 = 1, output FLOOR_FG, is_lit = 1.
REQ-035 With map[0] = 0, drive DrawX = 5, DrawY = 1 -> wall row 1 bit 26 = 0, output WALL_BG, is_lit = 0.
REQ-036 Drive DrawX = 700, DrawY = 100, pix_valid = 1 -> out_valid = 1, is_lit = 0, RGB = 0.
REQ-037 Write map_waddr = 300 with map_wdata = 1 -> all 300 entries unchanged (spot-check indices 0, 44, 299 read 0); write map[299] = 1 then DrawX = 639, DrawY = 479 -> floor row 31 (all zero) gives FLOOR_BG.
REQ-038 Stream 8 consecutive pixels and assert Reset at pixel 4 -> outputs 0 for the cycle after reset, map reads back all walls, and the pipeline resumes with correct 2-edge alignment.

Source files
------------

// File: rtl/tile_renderer.sv
// Tile-map background renderer.
// A 20x15 map of 32x32-pixel tiles (wall/floor) is looked up from the VGA
// draw coordinates. An external combinational sprite ROM supplies one 32-bit
// row per tile id and local row. Two pipeline stages produce one pixel per
// clock with a fixed latency of two edges.
module tile_renderer #(
  parameter logic [23:0] WALL_FG  = 24'hC0C0C0,
  parameter logic [23:0] WALL_BG  = 24'h404040,
  parameter logic [23:0] FLOOR_FG = 24'h208020,
  parameter logic [23:0] FLOOR_BG = 24'h102010
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid,
  input  logic        map_we,
  input  logic [8:0]  map_waddr,
  input  logic        map_wdata,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  output logic        is_lit,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  localparam int unsigned MAP_ENTRIES = 300;

  // Tile map: one bit per tile, 0 = wall, 1 = floor.
  logic [MAP_ENTRIES-1:0] map_q;

  // Stage A registers (only the low coordinate bits are needed downstream).
  logic [4:0] x_a_q;
  logic [4:0] y_a_q;
  logic       valid_a_q;
  logic       inr_a_q;
  logic       tile_a_q;

  // Stage B registers feed the outputs directly.
  logic        valid_b_q;
  logic        lit_b_q;
  logic [23:0] rgb_b_q;

  // Next-state values.
  logic [8:0]   map_idx;
  logic [511:0] map_ext;
  logic         inr_d;
  logic         tile_d;
  logic         bit_d;
  logic         lit_d;
  logic [23:0]  rgb_d;

  // Map lookup and colour selection for the two stages.
  always_comb begin
    // map index = 20*tileY + tileX, built as 16*ty + 4*ty + tx
    map_idx = {1'b0, DrawY[8:5], 4'b0000}
            + {3'b000, DrawY[8:5], 2'b00}
            + {4'b0000, DrawX[9:5]};
    // Zero-padded view so an out-of-range coordinate never indexes past the map.
    map_ext = {212'd0, map_q};
    inr_d   = (DrawX < 10'd640) && (DrawY < 10'd480);
    tile_d  = inr_d & map_ext[map_idx];

    // bit 31 is the leftmost pixel, so column c selects bit 31-c (= ~c in 5 bits)
    bit_d   = rom_data[~x_a_q];
    lit_d   = bit_d & inr_a_q;
    rgb_d   = 24'h000000;
    if (inr_a_q) begin
      if (tile_a_q) rgb_d = lit_d ? FLOOR_FG : FLOOR_BG;
      else          rgb_d = lit_d ? WALL_FG  : WALL_BG;
    end
  end

  // Tile map storage; writes outside 0..299 are dropped.
  always_ff @(posedge Clk) begin
    // NOTE: the map is a flop array, not a RAM, so it can and must be cleared
    // by reset; reset also wins over a write on the same edge.
    if (Reset) begin
      map_q <= '0;
    end else if (map_we && (map_waddr < 9'd300)) begin
      // NOTE: non-blocking write means a stage-A read on this same edge sees
      // the old value (read-before-write).
      map_q[map_waddr] <= map_wdata;
    end
  end

  // Two-stage pixel pipeline, flushed by reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_a_q     <= '0;
      y_a_q     <= '0;
      valid_a_q <= 1'b0;
      inr_a_q   <= 1'b0;
      tile_a_q  <= 1'b0;
      valid_b_q <= 1'b0;
      lit_b_q   <= 1'b0;
      rgb_b_q   <= '0;
    end else begin
      x_a_q     <= DrawX[4:0];
      y_a_q     <= DrawY[4:0];
      valid_a_q <= pix_valid;
      inr_a_q   <= inr_d;
      tile_a_q  <= tile_d;
      valid_b_q <= valid_a_q;
      lit_b_q   <= lit_d;
      rgb_b_q   <= rgb_d;
    end
  end

  assign rom_addr  = {tile_a_q, y_a_q};
  assign out_valid = valid_b_q;
  assign is_lit    = lit_b_q;
  assign Red       = rgb_b_q[23:16];
  assign Green     = rgb_b_q[15:8];
  assign Blue      = rgb_b_q[7:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer: expected pixels are pushed when driven
// and popped two edges later when the pipeline presents them.
module tb_tile_renderer;

  localparam logic [23:0] WFG = 24'hC0C0C0;
  localparam logic [23:0] WBG = 24'h404040;
  localparam logic [23:0] FFG = 24'h208020;
  localparam logic [23:0] FBG = 24'h102010;

  typedef struct packed {
    logic        valid;
    logic        lit;
    logic [23:0] rgb;
  } pix_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        pix_valid, map_we, map_wdata;
  logic [8:0]  map_waddr;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        out_valid, is_lit;
  logic [7:0]  Red, Green, Blue;

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t sb_q[$];
  bit   map_m[300];
  logic [5:0] exp_ra;

  tile_renderer #(
    .WALL_FG(WFG), .WALL_BG(WBG), .FLOOR_FG(FFG), .FLOOR_BG(FBG)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .map_we(map_we), .map_waddr(map_waddr),
    .map_wdata(map_wdata), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .is_lit(is_lit), .Red(Red), .Green(Green),
    .Blue(Blue)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM model: wall row 0 solid, wall row 1 left-edge only,
  // floor row 1 the documented pattern, floor row 31 empty.
  function automatic logic [31:0] rom_model(input logic [5:0] a);
    case (a)
      6'd0:    return 32'hFFFF_FFFF;
      6'd1:    return 32'hF800_0000;
      6'd33:   return 32'h07F8_1FE0;
      6'd63:   return 32'h0000_0000;
      default: return 32'h5A3C_96E1 ^ ({26'd0, a} * 32'h0101_0101);
    endcase
  endfunction

  always_comb rom_data = rom_model(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_out();
    pix_t e;
    e = sb_q.pop_front();
    check("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
    check("is_lit", {31'd0, is_lit}, {31'd0, e.lit});
    check("rgb", {8'd0, Red, Green, Blue}, {8'd0, e.rgb});
  endtask

  // One clock: drive a pixel (and optional map write), predict its output.
  task automatic cycle(input int x, input int y, input bit pv,
                       input bit we = 1'b0, input int wa = 0, input bit wd = 1'b0);
    pix_t e;
    bit inr, tile, b;
    logic [9:0] xv, yv;
    logic [31:0] row;
    xv = x[9:0];
    yv = y[9:0];
    DrawX = xv; DrawY = yv; pix_valid = pv;
    map_we = we; map_waddr = wa[8:0]; map_wdata = wd;
    inr  = (xv < 640) && (yv < 480);
    tile = inr ? map_m[(int'(yv) / 32) * 20 + int'(xv) / 32] : 1'b0;
    exp_ra = {tile, yv[4:0]};
    row  = rom_model(exp_ra);
    b    = row[31 - int'(xv[4:0])];
    e.valid = pv;
    e.lit   = b && inr;
    if (!inr)      e.rgb = 24'h0;
    else if (tile) e.rgb = e.lit ? FFG : FBG;
    else           e.rgb = e.lit ? WFG : WBG;
    sb_q.push_back(e);
    @(posedge Clk);
    if (we && wa < 300) map_m[wa] = wd;
    #1;
    check("rom_addr", {26'd0, rom_addr}, {26'd0, exp_ra});
    if (sb_q.size() >= 2) compare_out();
  endtask

  // Reset edge, optionally with a competing map write and a live pixel.
  task automatic do_reset();
    pix_t z;
    Reset = 1'b1;
    DrawX = 10'd40; DrawY = 10'd0; pix_valid = 1'b1;
    map_we = 1'b1; map_waddr = 9'd5; map_wdata = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    map_we = 1'b0;
    sb_q.delete();
    foreach (map_m[i]) map_m[i] = 1'b0;
    check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_is_lit", {31'd0, is_lit}, 32'd0);
    check("rst_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    // Stage B still holds the flushed stage A on the next edge.
    z = '0;
    sb_q.push_back(z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0;
    map_we = 1'b0; map_waddr = '0; map_wdata = 1'b0;
    @(posedge Clk);
    do_reset();

    // Origin pixel: solid wall row -> WALL_FG.
    cycle(0, 0, 1'b1);
    // Make tile 21 floor, then hit floor row 1, column 5.
    cycle(0, 0, 1'b0, 1'b1, 21, 1'b1);
    cycle(37, 33, 1'b1);
    // Wall row 1 column 5 is dark.
    cycle(5, 1, 1'b1);
    // Off-screen column.
    cycle(700, 100, 1'b1);
    // Illegal write address must not alias into the map.
    cycle(0, 0, 1'b0, 1'b1, 300, 1'b1);
    cycle(0, 0, 1'b1);
    cycle(128, 64, 1'b1);
    cycle(608, 448, 1'b1);
    // Last tile becomes floor; its bottom-right pixel uses the empty row.
    cycle(0, 0, 1'b0, 1'b1, 299, 1'b1);
    cycle(639, 479, 1'b1);
    cycle(640, 479, 1'b1);
    cycle(639, 480, 1'b0);

    // Mixed traffic with occasional writes, some past the end of the map.
    for (int i = 0; i < 24; i++) begin
      cycle($urandom_range(0, 800), $urandom_range(0, 560), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 320), 1'($urandom_range(0, 1)));
    end

    // Streaming eight pixels with reset landing on the fifth.
    cycle(0, 0, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) do_reset();
      else        cycle(i * 32, 0, 1'b1);
    end
    cycle(0, 0, 1'b1);

    // Drain the pipeline.
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
